// File: rtl/seg7_reader.sv
// Samples a multiplexed 4-digit 7-segment bus, debounces each digit and
// assembles decoded hex nibbles into 16-bit frames with a valid/ready output.
module seg7_reader #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  an,
   input  logic [6:0]  seg,
   input  logic        out_ready,
   output logic        out_valid,
   output logic [15:0] value,
   output logic [3:0]  err,
   output logic        overflow
);

   localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

   typedef enum logic {TRACK, HELD} state_t;

   state_t      r_state, w_state_nxt;
   logic [10:0] r_prev;
   logic        r_prev_vld;
   logic [3:0]  r_cnt, w_cnt_nxt;
   logic        w_same, w_onehot, w_capture;
   logic [15:0] r_shadow;
   logic [3:0]  r_shadow_err;
   logic [3:0]  r_seen, w_seen_nxt;
   logic        r_pend;
   logic        r_out_valid;
   logic [15:0] r_value;
   logic [3:0]  r_err;
   logic        r_overflow;
   logic [1:0]  w_idx;
   logic [3:0]  w_nib;
   logic        w_bad;

   // Exact-match glyph lookup; anything unrecognised decodes to 0 with error.
   function automatic logic [4:0] decode(input logic [6:0] s);
      case (s)
         7'h7E:   decode = 5'h00;
         7'h30:   decode = 5'h01;
         7'h6D:   decode = 5'h02;
         7'h79:   decode = 5'h03;
         7'h33:   decode = 5'h04;
         7'h5B:   decode = 5'h05;
         7'h5F:   decode = 5'h06;
         7'h70:   decode = 5'h07;
         7'h7F:   decode = 5'h08;
         7'h7B:   decode = 5'h09;
         7'h77:   decode = 5'h0A;
         7'h1F:   decode = 5'h0B;
         7'h4E:   decode = 5'h0C;
         7'h3D:   decode = 5'h0D;
         7'h4F:   decode = 5'h0E;
         7'h47:   decode = 5'h0F;
         default: decode = 5'h10;
      endcase
   endfunction

   assign w_same   = r_prev_vld && ({an, seg} == r_prev);
   assign w_onehot = $onehot(an);
   assign {w_bad, w_nib} = decode(seg);

   always_comb begin
      w_cnt_nxt = 4'd1;
      if (w_same) w_cnt_nxt = (r_cnt == STABLE) ? r_cnt : r_cnt + 4'd1;
   end

   always_comb begin
      w_idx = 2'd0;
      case (an)
         4'b0010: w_idx = 2'd1;
         4'b0100: w_idx = 2'd2;
         4'b1000: w_idx = 2'd3;
         default: w_idx = 2'd0;
      endcase
   end

   // Sampler FSM: HELD blocks recapture until the bus changes.
   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      case (r_state)
         TRACK: if (w_cnt_nxt == STABLE && w_onehot) begin
            w_capture   = 1'b1;
            w_state_nxt = HELD;
         end
         HELD: if (!w_same) w_state_nxt = TRACK;
         default: w_state_nxt = TRACK;
      endcase
   end

   // A frame hand-off clears seen first so a same-edge capture starts the next frame.
   assign w_seen_nxt = (r_pend ? 4'b0000 : r_seen) | (w_capture ? an : 4'b0000);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= TRACK;
         r_prev       <= '0;
         r_prev_vld   <= 1'b0;
         r_cnt        <= '0;
         r_shadow     <= '0;
         r_shadow_err <= '0;
         r_seen       <= '0;
         r_pend       <= 1'b0;
         r_out_valid  <= 1'b0;
         r_value      <= '0;
         r_err        <= '0;
         r_overflow   <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_prev     <= {an, seg};
         r_prev_vld <= 1'b1;
         r_cnt      <= w_cnt_nxt;
         r_seen     <= w_seen_nxt;
         r_pend     <= w_capture && (w_seen_nxt == 4'hF);
         r_overflow <= r_pend && r_out_valid && !out_ready;
         if (w_capture) begin
            r_shadow[w_idx*4 +: 4] <= w_nib;
            r_shadow_err[w_idx]    <= w_bad;
         end
         if (r_pend && (!r_out_valid || out_ready)) begin
            r_value     <= r_shadow;
            r_err       <= r_shadow_err;
            r_out_valid <= 1'b1;
         end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign value     = r_value;
   assign err       = r_err;
   assign overflow  = r_overflow;

endmodule

// File: tb/tb_seg7_reader.sv
// Directed and randomized checks of seg7_reader against a run-length based
// reference model of digit capture and frame hand-off.
module tb_seg7_reader;
   localparam int STABLE = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  an = '0;
   logic [6:0]  seg = '0;
   logic        out_ready = 1'b0;
   logic        out_valid;
   logic [15:0] value;
   logic [3:0]  err;
   logic        overflow;

   int tests = 0;
   int fails = 0;

   seg7_reader #(.STABLE_CYCLES(STABLE)) dut (
      .clk(clk), .rst(rst), .an(an), .seg(seg), .out_ready(out_ready),
      .out_valid(out_valid), .value(value), .err(err), .overflow(overflow)
   );

   always #5 clk = ~clk;

   logic [6:0] glyph [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                              7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

   // Reference model state
   logic [10:0] m_prev;
   bit          m_prev_vld;
   int          m_run;
   logic [3:0]  m_seen;
   logic [15:0] m_shadow;
   logic [3:0]  m_sherr;
   bit          m_pend;
   logic        m_ov;
   logic [15:0] m_val;
   logic [3:0]  m_err;
   logic        m_ovf;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_step(input logic [3:0] a, input logic [6:0] s,
                             input logic rdy, input logic r);
      bit cap;
      int idx;
      logic [3:0] nib;
      bit bad;
      if (r) begin
         m_prev_vld = 0; m_run = 0; m_seen = 0; m_shadow = 0; m_sherr = 0;
         m_pend = 0; m_ov = 0; m_val = 0; m_err = 0; m_ovf = 0;
         return;
      end
      // A digit is taken exactly when its run of identical samples hits STABLE.
      if (m_prev_vld && {a, s} == m_prev) m_run++;
      else m_run = 1;
      m_prev = {a, s};
      m_prev_vld = 1;
      cap = (m_run == STABLE) && ($countones(a) == 1);
      m_ovf = 0;
      if (m_pend) begin
         if (!m_ov || rdy) begin
            m_val = m_shadow; m_err = m_sherr; m_ov = 1;
         end else m_ovf = 1;
         m_seen = 0;
      end else if (m_ov && rdy) m_ov = 0;
      m_pend = 0;
      if (cap) begin
         idx = 0;
         for (int i = 0; i < 4; i++) if (a[i]) idx = i;
         nib = 0; bad = 1;
         for (int g = 0; g < 16; g++) if (glyph[g] == s) begin nib = 4'(g); bad = 0; end
         m_shadow[idx*4 +: 4] = nib;
         m_sherr[idx] = bad;
         m_seen[idx] = 1'b1;
         if (m_seen == 4'hF) m_pend = 1;
      end
   endtask

   task automatic tick(input logic [3:0] a, input logic [6:0] s, input logic rdy, input logic r);
      an = a; seg = s; out_ready = rdy; rst = r;
      @(posedge clk);
      model_step(a, s, rdy, r);
      #1;
      chk("out_valid", 32'(out_valid), 32'(m_ov));
      chk("value", 32'(value), 32'(m_val));
      chk("err", 32'(err), 32'(m_err));
      chk("overflow", 32'(overflow), 32'(m_ovf));
   endtask

   task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n, input logic rdy);
      for (int k = 0; k < n; k++) tick(a, s, rdy, 1'b0);
   endtask

   initial begin
      logic [3:0] ra;
      logic [6:0] rs;
      int n;

      // Reset state
      tick(4'b0000, 7'h00, 1'b0, 1'b1);
      tick(4'b0000, 7'h00, 1'b0, 1'b1);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_value", 32'(value), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_ovf", 32'(overflow), 0);

      // Basic frame 3210
      hold(4'b0001, 7'h7E, 4, 1'b1);
      hold(4'b0010, 7'h30, 4, 1'b1);
      hold(4'b0100, 7'h6D, 4, 1'b1);
      hold(4'b1000, 7'h79, 3, 1'b1);
      chk("pre_complete_valid", 32'(out_valid), 0);
      tick(4'b1000, 7'h79, 1'b1, 1'b0);
      chk("latency_not_yet", 32'(out_valid), 0);
      tick(4'b0000, 7'h00, 1'b1, 1'b0);
      chk("f1_valid", 32'(out_valid), 1);
      chk("f1_value", 32'(value), 32'h3210);
      chk("f1_err", 32'(err), 0);
      tick(4'b0000, 7'h00, 1'b1, 1'b0);
      chk("f1_drop", 32'(out_valid), 0);

      // Short hold: no capture
      hold(4'b0001, 7'h7F, 3, 1'b1);
      tick(4'b0000, 7'h00, 1'b1, 1'b0);

      // Illegal glyph on digit 2
      hold(4'b0001, 7'h7E, 4, 1'b1);
      hold(4'b0010, 7'h30, 4, 1'b1);
      hold(4'b0100, 7'h01, 4, 1'b1);
      hold(4'b1000, 7'h79, 4, 1'b1);
      tick(4'b0000, 7'h00, 1'b1, 1'b0);
      chk("ill_value", 32'(value), 32'h3010);
      chk("ill_err", 32'(err), 32'h4);
      tick(4'b0000, 7'h00, 1'b1, 1'b0);

      // Backpressure and overflow
      hold(4'b1000, 7'h77, 4, 1'b0);
      hold(4'b0100, 7'h1F, 4, 1'b0);
      hold(4'b0010, 7'h4E, 4, 1'b0);
      hold(4'b0001, 7'h3D, 4, 1'b0);
      tick(4'b0000, 7'h00, 1'b0, 1'b0);
      chk("bp_value", 32'(value), 32'hABCD);
      hold(4'b0001, 7'h30, 4, 1'b0);
      hold(4'b0010, 7'h30, 4, 1'b0);
      hold(4'b0100, 7'h30, 4, 1'b0);
      hold(4'b1000, 7'h30, 4, 1'b0);
      tick(4'b0000, 7'h00, 1'b0, 1'b0);
      chk("ovf_pulse", 32'(overflow), 1);
      chk("ovf_value_kept", 32'(value), 32'hABCD);
      tick(4'b0000, 7'h00, 1'b0, 1'b0);
      chk("ovf_one_cycle", 32'(overflow), 0);
      chk("bp_still_valid", 32'(out_valid), 1);
      tick(4'b0000, 7'h00, 1'b1, 1'b0);
      chk("bp_transfer_drop", 32'(out_valid), 0);

      // Illegal strobe, partial frame, then reset
      hold(4'b0011, 7'h7E, 10, 1'b1);
      hold(4'b0001, 7'h5B, 4, 1'b1);
      hold(4'b0010, 7'h5B, 4, 1'b1);
      tick(4'b0010, 7'h5B, 1'b1, 1'b1);
      chk("mid_rst_valid", 32'(out_valid), 0);
      hold(4'b0100, 7'h5F, 4, 1'b1);
      hold(4'b1000, 7'h70, 4, 1'b1);
      tick(4'b0000, 7'h00, 1'b1, 1'b0);
      chk("partial_discarded", 32'(out_valid), 0);
      hold(4'b0001, 7'h33, 4, 1'b1);
      hold(4'b0010, 7'h33, 4, 1'b1);
      tick(4'b0000, 7'h00, 1'b1, 1'b0);
      chk("post_rst_frame", 32'(value), 32'h7644);

      // Long hold, then out-of-order digits
      hold(4'b1000, 7'h4F, 20, 1'b1);
      hold(4'b1000, 7'h7B, 4, 1'b1);
      hold(4'b0010, 7'h5B, 4, 1'b1);
      hold(4'b0001, 7'h47, 4, 1'b1);
      hold(4'b0100, 7'h6D, 4, 1'b1);
      tick(4'b0000, 7'h00, 1'b1, 1'b0);
      chk("order_value", 32'(value), 32'h925F);
      chk("order_valid", 32'(out_valid), 1);

      // Randomized traffic
      for (int h = 0; h < 80; h++) begin
         ra = ($urandom_range(0, 4) != 0) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
         rs = ($urandom_range(0, 4) != 0) ? glyph[$urandom_range(0, 15)] : 7'($urandom_range(0, 127));
         n = $urandom_range(1, 7);
         if ($urandom_range(0, 39) == 0) tick(ra, rs, 1'b0, 1'b1);
         for (int k = 0; k < n; k++) tick(ra, rs, 1'($urandom_range(0, 3) != 0), 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/seg7_reader.md
SEG7_READER -- requirements
Module: seg7_reader

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, SHALL be the number of consecutive identical samples (range 2..15) required before a digit is accepted.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 an  input  4  digit strobe, active-high; bit i set means digit i is driven; only one-hot values are legal strobes.
REQ-005 seg  input  7  segments, active-high, seg[6]=a ... seg[0]=g (abcdefg order).
REQ-006 out_ready  input  1  consumer ready.
REQ-007 out_valid  output  1  a 16-bit frame is held on value.
REQ-008 value  output  16  decoded frame; nibble i (value[4i+3:4i]) comes from digit i.
REQ-009 err  output  4  per-digit flag, set when that digit's pattern was not a legal hex glyph.
REQ-010 overflow  output  1  one-cycle pulse marking that a completed frame was dropped.

Function
REQ-011 Decode SHALL be exact-match against these glyphs: 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=7B, A=77, b=1F, C=4E, d=3D, E=4F, F=47 (hex values of seg[6:0]).
REQ-012 Any other pattern SHALL decode to nibble 0 with the digit's err bit set; a legal pattern SHALL clear that err bit in the frame being assembled.
REQ-013 Stability counter cnt (4 bits) SHALL:
- increment, saturating at STABLE_CYCLES, on each edge where {an,seg} equals the value sampled on the previous edge;
- otherwise load 1.
REQ-014 Sampler FSM states are TRACK and HELD:
- TRACK -> HELD at the edge where cnt reaches STABLE_CYCLES and an is one-hot; the digit is captured at that edge.
- HELD -> TRACK at the first edge where {an,seg} changes.
REQ-015 A digit SHALL be captured at most once per continuous hold; a longer hold SHALL NOT recapture it.
REQ-016 If an is zero or not one-hot, there SHALL be no capture; the FSM enters TRACK and cnt still tracks the sample equality.
REQ-017 Capture SHALL write the decoded nibble and err bit into a shadow frame and set bit i of a 4-bit seen mask.
REQ-018 Recapturing an already-seen digit before the frame completes SHALL overwrite its nibble and err bit.
REQ-019 The frame is complete at the capture edge where seen becomes 1111, regardless of digit order. At the following edge:
- if out_valid is 0, or out_valid and out_ready are both 1, the shadow frame SHALL load into value/err and out_valid SHALL be 1;
- otherwise the frame SHALL be discarded and overflow SHALL pulse high for exactly one cycle.
REQ-020 In both cases of REQ-019, seen SHALL clear at the same edge.
REQ-021 A transfer occurs when out_valid and out_ready are both 1.
- After a transfer with no new frame loading, out_valid SHALL fall at the next edge.
- While out_valid is 1 and out_ready is 0, value and err SHALL stay stable.
REQ-022 Latency: out_valid SHALL rise exactly one edge after the completing capture edge.
REQ-023 A capture may occur on the same edge as a frame load; that capture SHALL belong to the next frame, so its seen bit is set after the clear.

Reset
REQ-024 With rst high at an edge, the block SHALL reset to:
- out_valid=0, overflow=0, value=0000, err=0000;
- seen=0000, shadow frame=0, cnt=0, FSM=TRACK.
REQ-025 Reset SHALL take priority over every other event, including mid-hold and mid-frame; a partial frame SHALL be discarded.
REQ-026 The first comparison after reset SHALL load cnt=1, so a full STABLE_CYCLES hold is needed after reset is released.

Verification
REQ-027 Hold an=0001/seg=7E, then 0010/30, then 0100/6D, then 1000/79, 4 cycles each, with out_ready=1 -> out_valid one edge after the last capture, value=3210, err=0000.
REQ-028 Hold an=0001/seg=7F for only 3 cycles, then change the input -> no capture; seen stays 0000.
REQ-029 Send a frame with digit 2 = 01 (illegal) and the others legal -> nibble 2=0, err=0100.
REQ-030 Set out_ready=0, complete frame 1 (value=ABCD), then complete frame 2 -> overflow pulses one cycle; value stays ABCD until out_ready rises.
REQ-031 Drive an=0011 for 10 cycles, then assert rst after two digits are captured -> no capture from the illegal strobe; after reset out_valid=0 and a full 4-digit frame is required.
REQ-032 Hold one digit for 20 cycles -> exactly one capture; sending digits in order 3,1,0,2 completes the frame normally.
